// File: rtl/nanov_reg_sequencer.sv
// Bit-serial register pass sequencer for the nanoV 1-bit register file.
// Runs one 32-cycle pass with one request queued behind it, so passes abut with no bubble.
module nanov_reg_sequencer #(
    parameter int unsigned REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [REG_ADDR_BITS-1:0] op_rs1,
    input  logic [REG_ADDR_BITS-1:0] op_rs2,
    input  logic [REG_ADDR_BITS-1:0] op_rd,
    input  logic                     op_wr,
    input  logic                     stall,
    output logic                     busy,
    output logic                     pass_done,
    output logic [4:0]               counter,
    output logic [REG_ADDR_BITS-1:0] rs1,
    output logic [REG_ADDR_BITS-1:0] rs2,
    output logic [REG_ADDR_BITS-1:0] rd,
    output logic [REG_ADDR_BITS-1:0] next_rs1,
    output logic [REG_ADDR_BITS-1:0] next_rs2,
    output logic                     wr_en,
    output logic                     wr_next_en,
    output logic                     read_through
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q, state_d;
    logic [4:0]               counter_q, counter_d;
    logic [REG_ADDR_BITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                     cur_wr_q, cur_wr_d;

    logic                     pend_valid_q, pend_valid_d;
    logic [REG_ADDR_BITS-1:0] pend_rs1_q, pend_rs1_d, pend_rs2_q, pend_rs2_d;
    logic [REG_ADDR_BITS-1:0] pend_rd_q, pend_rd_d;
    logic                     pend_wr_q, pend_wr_d;

    logic                     accept, run, advance, wrap, wr_act, next_avail;
    logic [REG_ADDR_BITS-1:0] src_rs1, src_rs2, src_rd;
    logic                     src_wr;

    assign op_ready = !pend_valid_q;
    assign accept   = op_valid && op_ready;
    assign run      = (state_q == StRun);
    assign advance  = run && !stall;
    assign wrap     = advance && (counter_q == 5'd31);

    // The next pass comes from the pending slot, or straight from the input when it is empty.
    assign next_avail = pend_valid_q || accept;
    assign src_rs1    = pend_valid_q ? pend_rs1_q : op_rs1;
    assign src_rs2    = pend_valid_q ? pend_rs2_q : op_rs2;
    assign src_rd     = pend_valid_q ? pend_rd_q  : op_rd;
    assign src_wr     = pend_valid_q ? pend_wr_q  : op_wr;

    // x0 is hardwired zero; x3/x4 (gp/tp) are not backed by storage in this register file.
    assign wr_act = cur_wr_q && (rd_q != '0)
                    && (rd_q != REG_ADDR_BITS'(3)) && (rd_q != REG_ADDR_BITS'(4));

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        cur_wr_d     = cur_wr_q;
        pend_valid_d = pend_valid_q;
        pend_rs1_d   = pend_rs1_q;
        pend_rs2_d   = pend_rs2_q;
        pend_rd_d    = pend_rd_q;
        pend_wr_d    = pend_wr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StRun;
                    counter_d = 5'd0;
                    rs1_d     = op_rs1;
                    rs2_d     = op_rs2;
                    rd_d      = op_rd;
                    cur_wr_d  = op_wr;
                end
            end
            StRun: begin
                if (wrap) begin
                    counter_d = 5'd0;
                    if (next_avail) begin
                        rs1_d        = src_rs1;
                        rs2_d        = src_rs2;
                        rd_d         = src_rd;
                        cur_wr_d     = src_wr;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (advance) begin
                        counter_d = counter_q + 5'd1;
                    end
                    if (accept) begin
                        pend_valid_d = 1'b1;
                        pend_rs1_d   = op_rs1;
                        pend_rs2_d   = op_rs2;
                        pend_rd_d    = op_rd;
                        pend_wr_d    = op_wr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            counter_q    <= 5'd0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            cur_wr_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_rs1_q   <= '0;
            pend_rs2_q   <= '0;
            pend_rd_q    <= '0;
            pend_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            cur_wr_q     <= cur_wr_d;
            pend_valid_q <= pend_valid_d;
            pend_rs1_q   <= pend_rs1_d;
            pend_rs2_q   <= pend_rs2_d;
            pend_rd_q    <= pend_rd_d;
            pend_wr_q    <= pend_wr_d;
        end
    end

    always_comb begin
        next_rs1 = rs1_q;
        next_rs2 = rs2_q;
        if (!run) begin
            next_rs1 = op_rs1;
            next_rs2 = op_rs2;
        end else if (wrap && next_avail) begin
            next_rs1 = src_rs1;
            next_rs2 = src_rs2;
        end
    end

    assign busy         = run;
    assign counter      = counter_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign rd           = rd_q;
    assign pass_done    = wrap;
    assign wr_en        = advance && wr_act;
    // Bit 31 is the last of this pass; the following bit belongs to the next one.
    assign wr_next_en   = wr_en && (counter_q != 5'd31);
    assign read_through = wrap && wr_act && next_avail;

endmodule

// File: doc/nanov_reg_sequencer.md
Name: nanov_reg_sequencer

Overview:
- Sequences bit-serial passes over the nanoV 1-bit register file; turns per-instruction register requests into per-cycle register file controls.
- Per request, generates a 32-cycle pass with these outputs:
  - a bit counter;
  - latched rs1/rs2/rd;
  - lookahead next_rs1/next_rs2;
  - write enables for the current bit and the next bit;
  - the read-through flag for back-to-back passes.
- Sits between the core decode stage and the register file. Holds one pass in flight plus one pending request, so passes run back-to-back with no bubble.

Parameters:
- REG_ADDR_BITS, 4, width of register addresses. RV32E is 16 registers; x0 reads zero.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- op_valid  in  1  request present.
- op_ready  out  1  sequencer can accept a request this cycle.
- op_rs1  in  REG_ADDR_BITS  source register 1 of request.
- op_rs2  in  REG_ADDR_BITS  source register 2 of request.
- op_rd  in  REG_ADDR_BITS  destination register of request.
- op_wr  in  1  request writes rd.
- stall  in  1  freeze current pass (pause).
- busy  out  1  a pass is in progress.
- pass_done  out  1  one-cycle pulse on the final bit (counter 31, not stalled).
- counter  out  5  bit index of current pass.
- rs1  out  REG_ADDR_BITS  current-pass source 1.
- rs2  out  REG_ADDR_BITS  current-pass source 2.
- rd  out  REG_ADDR_BITS  current-pass destination.
- next_rs1  out  REG_ADDR_BITS  source 1 read on the next cycle.
- next_rs2  out  REG_ADDR_BITS  source 2 read on the next cycle.
- wr_en  out  1  write current bit of rd.
- wr_next_en  out  1  write next bit of rd.
- read_through  out  1  next pass may bypass rd result.

Behaviour:
- Reset (async, rstn=0) forces the following, independent of clk, including mid-pass:
  - state IDLE, pending empty;
  - counter=0, rs1=rs2=rd=0, cur_wr=0;
  - busy=0, pass_done=0, wr_en=0, wr_next_en=0, read_through=0;
  - op_ready=1.
- States:
  - IDLE: no pass.
  - RUN: pass active.
  - Pause is RUN with stall=1; it is not a separate state.
- Handshake:
  - Accept = op_valid & op_ready.
  - op_ready = !pend_valid. The request fields are captured on the accept edge.
- IDLE + accept:
  - Next cycle: RUN, counter=0, rs1/rs2/rd/cur_wr loaded from the request.
  - The pending slot is bypassed.
  - Latency from accept to first bit is 1 cycle.
- RUN + accept: the request goes into the pending slot (pend_valid=1).
- RUN, stall=0: counter increments.
- RUN, stall=1: counter and all state hold. wr_en, wr_next_en, read_through and pass_done are forced 0.
- counter==31 & stall=0:
  - pass_done=1.
  - If pend_valid (or an accept in the same cycle with pend_valid=0): load the pending (or bypassed) request, counter wraps to 0, stay RUN. No idle cycle.
  - Else: go to IDLE, counter=0.
- busy = (state==RUN).
- Write enable gating, with wr_act = cur_wr & (rd!=0) & (rd!=3) & (rd!=4):
  - wr_en = RUN & !stall & wr_act. This includes counter 31.
  - wr_next_en = wr_en & (counter!=31). The bit after 31 belongs to the next pass.
- next_rs1/next_rs2 (combinational):
  - IDLE: op_rs1/op_rs2, so the register file preloads before the first bit.
  - RUN, counter==31, !stall: the rs fields of the request being loaded (pending, else bypassed input). If none is available, the current rs.
  - Otherwise: current rs1/rs2.
- read_through = RUN & !stall & counter==31 & wr_act & next-pass request available. The register file compares next_rs with rd itself.
- Simultaneous events:
  - Accept and wrap on the same edge with pending empty: the request loads directly as the new current pass.
  - Accept while pend_valid: impossible (op_ready=0).
  - stall asserted at counter==31: the wrap is deferred until stall drops.
- rd=0 with op_wr=1: the pass runs, but wr_en and wr_next_en stay 0.

Test Plan:
- Reset then single op (rs1=5, rs2=6, rd=7, wr=1) accepted at T:
  - busy=1 at T+1 with counter=0.
  - wr_en=1 for 32 cycles; wr_next_en=1 for counters 0..30 only.
  - pass_done pulses at counter 31; IDLE at T+33.
- Two back-to-back ops (second rs1=7 after rd=7):
  - Second is accepted into pending during the first pass.
  - At counter 31: read_through=1, next_rs1=7.
  - Next cycle: counter=0, rs1=7, busy stays 1 (no gap).
- stall held for 5 cycles at counter=10:
  - counter stays 10; wr_en, wr_next_en, pass_done are 0.
  - On release, counter resumes at 11 and the pass ends 5 cycles late.
- Ops with rd=0 and rd=3, wr=1: full 32-cycle passes; wr_en, wr_next_en and read_through never assert.
- Pending full: op_valid held during the first pass with a second op already pending gives op_ready=0 until the wrap edge, then op_ready=1.
- rstn pulsed low at counter=17 with pending valid: all outputs reach reset values immediately; after release, op_ready=1, IDLE, and the pending request is discarded.
